// File: rtl/packer_if.sv
// Stream interface for the packer: narrow item input side and wide word output side.
interface packer_if #(
    parameter int unsigned UnpackedWidth = 2,
    parameter int unsigned PackedNum     = 4
);
    localparam int unsigned PackedWidth = UnpackedWidth * PackedNum;

    logic [UnpackedWidth-1:0] unpacked_i;
    logic                     valid_i;
    logic                     ready_o;
    logic                     flush_i;
    logic [PackedWidth-1:0]   packed_o;
    logic                     valid_o;
    logic                     ready_i;
    logic                     done_o;

    modport master (
        output unpacked_i, valid_i, flush_i, ready_i,
        input  ready_o, packed_o, valid_o, done_o
    );

    modport slave (
        input  unpacked_i, valid_i, flush_i, ready_i,
        output ready_o, packed_o, valid_o, done_o
    );
endinterface

// File: rtl/packer.sv
// Gathers PackedNum narrow items (item 0 in the LSBs) into one wide word held in a registered
// output stage. Define PACKER_FLUSH_EN to let flush_i close a word early.
module packer #(
    parameter int unsigned UnpackedWidth = 2,
    parameter int unsigned PackedNum     = 4
) (
    input logic     clk_i,
    input logic     rst_ni,
    packer_if.slave bus
);
    localparam int unsigned PackedWidth = UnpackedWidth * PackedNum;
    localparam int unsigned CountWidth  = $clog2(PackedNum);
    localparam logic [CountWidth-1:0] LastSlot = CountWidth'(PackedNum - 1);

    logic [CountWidth-1:0]  count_q, count_d;
    logic [PackedWidth-1:0] acc_q, acc_d;
    logic [PackedWidth-1:0] packed_q, packed_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic [PackedWidth-1:0] merged_c;
    logic                   flush_c, final_c, in_fire_c, out_fire_c;

`ifdef PACKER_FLUSH_EN
    assign flush_c = bus.flush_i;
`else
    logic unused_flush;
    assign unused_flush = bus.flush_i;
    assign flush_c      = 1'b0;
`endif

    // The final item may only enter when the output stage is free or draining now.
    assign final_c     = (count_q == LastSlot) | flush_c;
    assign bus.ready_o = ~final_c | ~valid_q | bus.ready_i;
    assign in_fire_c   = bus.valid_i & bus.ready_o;
    assign out_fire_c  = valid_q & bus.ready_i;

    // Slots at and above count are zero in the accumulator, so OR-ing places the item.
    assign merged_c = acc_q | (PackedWidth'(bus.unpacked_i) << (int'(count_q) * UnpackedWidth));

    always_comb begin
        count_d  = count_q;
        acc_d    = acc_q;
        packed_d = packed_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        if (out_fire_c) begin
            valid_d = 1'b0;
        end
        if (in_fire_c) begin
            if (final_c) begin
                packed_d = merged_c;
                valid_d  = 1'b1;
                done_d   = 1'b1;
                count_d  = '0;
                acc_d    = '0;
            end else begin
                acc_d   = merged_c;
                count_d = count_q + CountWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q  <= '0;
            acc_q    <= '0;
            packed_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            acc_q    <= acc_d;
            packed_q <= packed_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign bus.packed_o = packed_q;
    assign bus.valid_o  = valid_q;
    assign bus.done_o   = done_q;
endmodule

// File: tb/tb_packer.sv
// Self-checking bench for packer (UnpackedWidth=2, PackedNum=4): directed vector table,
// a mid-word reset sequence, and a randomized run against a queue-based reference model.
module tb_packer;
    localparam int unsigned UW = 2;
    localparam int unsigned PN = 4;
    localparam int unsigned PW = UW * PN;

`ifdef PACKER_FLUSH_EN
    localparam bit FlushEn = 1'b1;
`else
    localparam bit FlushEn = 1'b0;
`endif

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    packer_if #(.UnpackedWidth(UW), .PackedNum(PN)) bus ();

    packer #(.UnpackedWidth(UW), .PackedNum(PN)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit            rst_n;
        bit            valid;
        logic [UW-1:0] item;
        bit            flush;
        bit            rdy;
        bit            e_ready;
        bit            e_valid;
        logic [PW-1:0] e_packed;
        bit            e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit rst_n, bit valid, logic [UW-1:0] item, bit flush, bit rdy,
                               bit e_ready, bit e_valid, logic [PW-1:0] e_packed, bit e_done);
        vec_t r;
        r.rst_n = rst_n; r.valid = valid; r.item = item; r.flush = flush; r.rdy = rdy;
        r.e_ready = e_ready; r.e_valid = e_valid; r.e_packed = e_packed; r.e_done = e_done;
        return r;
    endfunction

    function automatic logic [PW-1:0] build_word(input int unsigned items[$]);
        logic [PW-1:0] w = '0;
        for (int i = 0; i < items.size(); i++) w = w | (PW'(items[i]) << (UW * i));
        return w;
    endfunction

    // One cycle: drive, check ready_o before the edge, check registered outputs after it.
    task automatic step(input bit rst_n, input bit valid, input logic [UW-1:0] item, input bit flush,
                        input bit rdy, input bit e_ready, input bit e_valid,
                        input logic [PW-1:0] e_packed, input bit e_done, input string tag);
        rst_ni         = rst_n;
        bus.valid_i    = valid;
        bus.unpacked_i = item;
        bus.flush_i    = flush;
        bus.ready_i    = rdy;
        #1;
        chk({tag, "_ready"}, 32'(bus.ready_o), 32'(e_ready));
        @(posedge clk_i);
        #1;
        chk({tag, "_valid"}, 32'(bus.valid_o), 32'(e_valid));
        chk({tag, "_packed"}, 32'(bus.packed_o), 32'(e_packed));
        chk({tag, "_done"}, 32'(bus.done_o), 32'(e_done));
    endtask

    // Reference model state for the random run.
    int unsigned   cur[$];
    logic [PW-1:0] sb[$];
    bit            st_full;
    logic [PW-1:0] st_word;
    bit            done_exp;

    initial begin
        int unsigned   accepted;
        int unsigned   cycles;
        int unsigned   words_model;
        int unsigned   words_dut;
        bit            m_final, exp_ready, in_fire, out_fire, stalled;
        logic [PW-1:0] prev_word;

        bus.valid_i = 1'b0; bus.unpacked_i = '0; bus.flush_i = 1'b0; bus.ready_i = 1'b0;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        // Basic word then streaming second word
        vecs.push_back(v(0,0,0,0,0, 1,0,8'h00,0));
        vecs.push_back(v(1,1,1,0,1, 1,0,8'h00,0));
        vecs.push_back(v(1,1,2,0,1, 1,0,8'h00,0));
        vecs.push_back(v(1,1,3,0,1, 1,0,8'h00,0));
        vecs.push_back(v(1,1,0,0,1, 1,1,8'h39,1));
        vecs.push_back(v(1,1,0,0,1, 1,0,8'h39,0));
        vecs.push_back(v(1,1,0,0,1, 1,0,8'h39,0));
        vecs.push_back(v(1,1,0,0,1, 1,0,8'h39,0));
        vecs.push_back(v(1,1,3,0,1, 1,1,8'hC0,1));
        vecs.push_back(v(1,0,0,0,1, 1,0,8'hC0,0));
        // Backpressure: final item of second word stalls until ready_i
        vecs.push_back(v(0,0,0,0,0, 1,0,8'h00,0));
        vecs.push_back(v(1,1,1,0,0, 1,0,8'h00,0));
        vecs.push_back(v(1,1,2,0,0, 1,0,8'h00,0));
        vecs.push_back(v(1,1,3,0,0, 1,0,8'h00,0));
        vecs.push_back(v(1,1,0,0,0, 1,1,8'h39,1));
        vecs.push_back(v(1,1,0,0,0, 1,1,8'h39,0));
        vecs.push_back(v(1,1,0,0,0, 1,1,8'h39,0));
        vecs.push_back(v(1,1,0,0,0, 1,1,8'h39,0));
        vecs.push_back(v(1,1,3,0,0, 0,1,8'h39,0));
        vecs.push_back(v(1,1,3,0,0, 0,1,8'h39,0));
        vecs.push_back(v(1,1,3,0,1, 1,1,8'hC0,1));
        vecs.push_back(v(1,0,0,0,1, 1,0,8'hC0,0));
        // Flush behaviour
        vecs.push_back(v(0,0,0,0,0, 1,0,8'h00,0));
        if (FlushEn) begin
            vecs.push_back(v(1,1,3,0,1, 1,0,8'h00,0));
            vecs.push_back(v(1,1,1,1,1, 1,1,8'h07,1));
            vecs.push_back(v(1,1,1,0,1, 1,0,8'h07,0));
            vecs.push_back(v(1,1,2,0,1, 1,0,8'h07,0));
            vecs.push_back(v(1,1,3,0,1, 1,0,8'h07,0));
            vecs.push_back(v(1,1,0,0,1, 1,1,8'h39,1));
        end else begin
            vecs.push_back(v(1,1,3,0,1, 1,0,8'h00,0));
            vecs.push_back(v(1,1,1,1,1, 1,0,8'h00,0));
            vecs.push_back(v(1,1,1,0,1, 1,0,8'h00,0));
            vecs.push_back(v(1,1,2,0,1, 1,1,8'h97,1));
            vecs.push_back(v(1,1,3,0,1, 1,0,8'h97,0));
            vecs.push_back(v(1,1,0,0,1, 1,0,8'h97,0));
        end

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].valid, vecs[i].item, vecs[i].flush, vecs[i].rdy,
                 vecs[i].e_ready, vecs[i].e_valid, vecs[i].e_packed, vecs[i].e_done,
                 $sformatf("vec%0d", i));
        end

        // Reset mid-word: partial word 1,2 discarded, only 0,0,0,3 -> C0 emerges
        step(0,0,0,0,1, 1,0,8'h00,0, "mr_rst0");
        step(1,1,1,0,1, 1,0,8'h00,0, "mr_a");
        step(1,1,2,0,1, 1,0,8'h00,0, "mr_b");
        step(0,1,3,0,1, 1,0,8'h00,0, "mr_rst");
        step(1,0,0,0,1, 1,0,8'h00,0, "mr_idle");
        step(1,1,0,0,1, 1,0,8'h00,0, "mr_c");
        step(1,1,0,0,1, 1,0,8'h00,0, "mr_d");
        step(1,1,0,0,1, 1,0,8'h00,0, "mr_e");
        step(1,1,3,0,1, 1,1,8'hC0,1, "mr_f");
        step(1,0,0,0,1, 1,0,8'hC0,0, "mr_g");

        // Randomized run against the transaction-level model
        step(0,0,0,0,0, 1,0,8'h00,0, "rnd_rst");
        rst_ni = 1'b1;
        cur.delete(); sb.delete();
        st_full = 1'b0; st_word = '0; done_exp = 1'b0;
        accepted = 0; cycles = 0; words_model = 0; words_dut = 0;
        while (accepted < 10000 && cycles < 60000) begin
            bus.valid_i    = ($urandom_range(0, 99) < 70);
            bus.unpacked_i = UW'($urandom);
            bus.flush_i    = ($urandom_range(0, 99) < 10);
            bus.ready_i    = ($urandom_range(0, 99) < 65);
            #1;
            m_final   = (cur.size() == PN - 1) || (FlushEn && bus.flush_i);
            exp_ready = !m_final || !st_full || bus.ready_i;
            chk("rnd_ready", 32'(bus.ready_o), 32'(exp_ready));
            in_fire  = bus.valid_i && exp_ready;
            out_fire = st_full && bus.ready_i;
            stalled  = st_full && !bus.ready_i;
            prev_word = bus.packed_o;
            if (out_fire) begin
                if (sb.size() == 0) chk("rnd_sb_empty", 32'(sb.size()), 32'd1);
                else chk("rnd_deliver", 32'(bus.packed_o), 32'(sb.pop_front()));
            end
            done_exp = 1'b0;
            if (out_fire) st_full = 1'b0;
            if (in_fire) begin
                accepted++;
                cur.push_back(int'(bus.unpacked_i));
                if (m_final) begin
                    st_word = build_word(cur);
                    sb.push_back(st_word);
                    st_full = 1'b1;
                    done_exp = 1'b1;
                    words_model++;
                    cur.delete();
                end
            end
            @(posedge clk_i);
            #1;
            cycles++;
            if (bus.done_o === 1'b1) words_dut++;
            chk("rnd_valid", 32'(bus.valid_o), 32'(st_full));
            chk("rnd_done", 32'(bus.done_o), 32'(done_exp));
            if (st_full) chk("rnd_packed", 32'(bus.packed_o), 32'(st_word));
            if (stalled) chk("rnd_stable", 32'(bus.packed_o), 32'(prev_word));
        end
        if (accepted < 10000) chk("rnd_timeout", accepted, 32'd10000);
        chk("rnd_word_count", words_dut, words_model);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
